// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   A bit-serial add/subtract sequencer. One full-adder slice (two half adders
//   plus a carry OR) is reused for WIDTH cycles, processing the operands
//   LSB-first. The carry between bits is held in a flop.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When it is defined, the block has a 'sub' port. It is captured together
//     with the operands. sub=1 inverts B per bit and presets the carry to 1,
//     which gives a two's-complement subtract.
//     When it is undefined, the block only adds.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request; sampled only while IDLE
//   a, b   WIDTH-bit operands, captured when start is accepted
//   sub    subtract select (present only with SERIAL_ADDER_SUB_EN)
//   busy   high in RUN and DONE
//   done   one-cycle pulse when sum/cout are valid
//   sum    result; bits are shifted in at the MSB
//   cout   final carry-out (for subtract, 1 = no borrow)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q, sub_d;
`endif

  // Shared one-bit slice
  logic b_bit, p_bit, s_bit, c_next;

  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_bit = sub_q ? ~b_q[0] : b_q[0];
`else
    b_bit = b_q[0];
`endif
    p_bit  = a_q[0] ^ b_bit;                          // first half adder
    s_bit  = p_bit ^ carry_q;                         // second half adder
    c_next = (a_q[0] & b_bit) | (p_bit & carry_q);    // carry OR
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub;
          carry_d = sub;   // +1 completes the two's complement of B
`else
          carry_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        if (cnt_q == CW'(WIDTH-1)) begin
          // The counter stays at WIDTH-1 here. The next accepted start clears it.
          cout_d  = c_next;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // The request line is not looked at here, so a start in this cycle is dropped.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl.
// Directed cases run on a WIDTH=8 instance. Random back-to-back traffic runs
// on a WIDTH=8 instance and a WIDTH=32 instance at the same time.
// Expected results come from plain integer arithmetic.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic        s8_start = 1'b0;
  logic [7:0]  s8_a = '0, s8_b = '0, s8_sum;
  logic        s8_busy, s8_done, s8_cout;
  // WIDTH=32 instance
  logic        s32_start = 1'b0;
  logic [31:0] s32_a = '0, s32_b = '0, s32_sum;
  logic        s32_busy, s32_done, s32_cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic        s8_sub = 1'b0, s32_sub = 1'b0;
`endif

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(s8_sub),
`endif
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout));

  serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32_start), .a(s32_a), .b(s32_b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(s32_sub),
`endif
    .busy(s32_busy), .done(s32_done), .sum(s32_sum), .cout(s32_cout));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {cout, sum} for a W-bit operation.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input int w);
    logic [63:0] mask, av, bv, r;
    logic        c;
    mask = (64'd1 << w) - 64'd1;
    av = {32'd0, a} & mask;
    bv = {32'd0, b} & mask;
    if (sub) begin
      r = (av - bv) & mask;
      c = (av >= bv);
    end else begin
      r = (av + bv) & mask;
      c = ((av + bv) >> w) != 0;
    end
    model = {c, r[31:0]};
  endfunction

  // Present an operation and let the next edge accept it. Returns at #1 after
  // that edge, with start already dropped.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    @(negedge clk);
    s8_a = a; s8_b = b; s8_start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    s8_sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
    @(posedge clk); #1;
    s8_start = 1'b0;
    chk("busy_after_accept", s8_busy, 1'b1);
  endtask

  // Count edges until done is seen. The count is bounded; an expired bound
  // shows up as a wrong latency.
  task automatic wait8(output int n);
    n = 0;
    while (!s8_done && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input string tag);
    int n;
    logic [32:0] e;
    e = model({24'd0, a}, {24'd0, b}, sub, 8);
    go8(a, b, sub);
    wait8(n);
    // done is expected in the cycle after the WIDTH-th edge following acceptance.
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, s8_sum, e[7:0]);
    chk({tag, "_cout"}, s8_cout, e[32]);
  endtask

  initial begin
    int n, dn;
    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", s8_busy, 0);  chk("rst_done", s8_done, 0);
    chk("rst_sum", s8_sum, 0);    chk("rst_cout", s8_cout, 0);
    chk("rst32_busy", s32_busy, 0); chk("rst32_sum", s32_sum, 0);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- basic add
    op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    chk("add_5a_3c_sum_const", s8_sum, 8'h96);
    @(posedge clk); #1;
    chk("post_done_busy", s8_busy, 0); chk("post_done_done", s8_done, 0);

    // ---------------- carry-out and hold
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", s8_sum, 8'h00);
      chk("hold_cout", s8_cout, 1'b1);
      chk("hold_done", s8_done, 1'b0);
    end

    // ---------------- start held through busy is ignored, then accepted in IDLE
    go8(8'h10, 8'h20, 1'b0);
    s8_a = 8'hFF; s8_b = 8'hFF; s8_start = 1'b1;
    wait8(n);
    chk("ign_lat", n, 8);
    chk("ign_sum", s8_sum, 8'h30); chk("ign_cout", s8_cout, 1'b0);
    @(posedge clk); #1;                 // DONE -> IDLE, so start is ignored here
    chk("ign_done_cyc_busy", s8_busy, 0);
    @(posedge clk); #1;                 // accepted in IDLE
    s8_start = 1'b0;
    chk("second_accept_busy", s8_busy, 1);
    wait8(n);
    chk("second_lat", n, 8);
    chk("second_sum", s8_sum, 8'hFE); chk("second_cout", s8_cout, 1'b1);
    @(posedge clk); #1;

    // ---------------- reset in the 4th RUN cycle
    go8(8'hAA, 8'h55, 1'b0);             // now in RUN cycle 1
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;                    // during RUN cycle 4
    @(posedge clk); #1;
    chk("midrst_busy", s8_busy, 0); chk("midrst_done", s8_done, 0);
    chk("midrst_sum", s8_sum, 0);   chk("midrst_cout", s8_cout, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (s8_done) dn++; end
    chk("midrst_no_done", dn, 0);

`ifdef SERIAL_ADDER_SUB_EN
    // ---------------- subtract
    op8(8'h10, 8'h01, 1'b1, "sub_10_01");
    chk("sub_10_01_const", {s8_cout, s8_sum}, 9'h10F);
    @(posedge clk); #1;
    op8(8'h01, 8'h02, 1'b1, "sub_01_02");
    chk("sub_01_02_const", {s8_cout, s8_sum}, 9'h0FF);
    @(posedge clk); #1;
`endif

    // ---------------- random back-to-back, both widths at once
    fork
      begin : rnd8
        int unsigned last;
        int m;
        logic sb;
        logic [32:0] e;
        last = 0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          sb = 1'($urandom_range(0, 1));
          s8_sub = sb;
`endif
          s8_a = 8'($urandom); s8_b = 8'($urandom); s8_start = 1'b1;
          e = model({24'd0, s8_a}, {24'd0, s8_b}, sb, 8);
          @(posedge clk); #1;
          chk("r8_busy", s8_busy, 1);
          s8_a = 8'($urandom); s8_b = 8'($urandom);   // must not disturb the operation
          m = 0;
          while (!s8_done && m < 100) begin @(posedge clk); #1; m++; end
          chk("r8_lat", m, 8);
          chk("r8_sum", s8_sum, e[7:0]);
          chk("r8_cout", s8_cout, e[32]);
          if (i > 0) chk("r8_spacing", cyc - last, 10);
          last = cyc;
          @(posedge clk); #1;                         // DONE cycle: start stays high and is dropped
          chk("r8_idle", s8_busy, 0);
        end
        s8_start = 1'b0;
      end
      begin : rnd32
        int unsigned last;
        int m;
        logic sb;
        logic [32:0] e;
        last = 0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          sb = 1'($urandom_range(0, 1));
          s32_sub = sb;
`endif
          s32_a = $urandom; s32_b = $urandom; s32_start = 1'b1;
          if (i == 0) begin s32_a = 32'hFFFF_FFFF; s32_b = 32'h1; end
          e = model(s32_a, s32_b, sb, 32);
          @(posedge clk); #1;
          chk("r32_busy", s32_busy, 1);
          s32_a = $urandom; s32_b = $urandom;
          m = 0;
          while (!s32_done && m < 200) begin @(posedge clk); #1; m++; end
          chk("r32_lat", m, 32);
          chk("r32_sum", s32_sum, e[31:0]);
          chk("r32_cout", s32_cout, e[32]);
          if (i > 0) chk("r32_spacing", cyc - last, 34);
          last = cyc;
          @(posedge clk); #1;
          chk("r32_idle", s32_busy, 0);
        end
        s32_start = 1'b0;
      end
    join

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer that reuses a single one-bit adder slice (two half-adder cells plus carry OR) over WIDTH cycles to add two WIDTH-bit operands. It captures operands on a start request, steps the slice LSB-first while holding the carry in a flip-flop, and returns sum and carry-out with a done pulse. It sits between a requesting controller and the shared one-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result valid
- sum  output  WIDTH  result, LSB-first shifted in
- cout  output  1  final carry-out
- One clock; reset is synchronous and active-low.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 -> load a into shift reg A, b into shift reg B, clear bit counter to 0, carry flop = 0 (add) or 1 (sub), go RUN. start=0 -> stay.
- RUN: each cycle slice computes s = A[0]^B'[0]^carry and c_next = (A[0]&B'[0]) | ((A[0]^B'[0])&carry), where B' = B (add) or ~B (sub). s shifts into sum MSB, sum shifts right; A, B shift right; carry <= c_next; counter++.
- Counter == WIDTH-1 during RUN -> after that bit, cout <= c_next, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- sum and cout hold their last value from DONE through IDLE until the next accepted start; they change only during RUN.
- start while busy: ignored, not queued. start in the DONE cycle: ignored.
- a, b changes after capture: no effect on the in-flight operation.
- Arithmetic: sum = (a + b) mod 2^WIDTH; cout = bit WIDTH of a+b. Sub: sum = (a - b) mod 2^WIDTH; cout = 1 when a >= b (no borrow), 0 otherwise.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, carry=0, counter=0, state IDLE.
- rst_n=0 at any edge, including mid-RUN or in DONE: next cycle all of the above reset values; in-flight operation discarded, no done pulse.
- start accepted at edge T (state IDLE) -> busy=1 from T+1; RUN occupies cycles T+1..T+WIDTH; done=1 and final sum/cout visible in cycle T+WIDTH+1; busy=0 and state IDLE from T+WIDTH+2.
- Latency start->done: WIDTH+1 cycles. Throughput: one operation per WIDTH+2 cycles (next start accepted earliest at T+WIDTH+2).
- done and busy are registered outputs; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists, captured with operands on accepted start; sub=1 selects two's-complement subtract (B inverted per bit, carry preset to 1).
- Not defined: sub port absent, carry always preset to 0, B never inverted; block is add-only. All other timing identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> done exactly 9 cycles after accept edge, sum=0x96, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; sum/cout held unchanged for 5 idle cycles after done.
- Accepted start a=0x10, b=0x20, then start=1 with a=0xFF, b=0xFF held through busy -> one done only, sum=0x30, cout=0; second request accepted only once IDLE, giving sum=0xFE, cout=1.
- Start a=0xAA, b=0x55, assert rst_n=0 in the 4th RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse follows.
- With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
- Random back-to-back operations (1000, WIDTH=8 and WIDTH=32), start reasserted immediately on IDLE -> every result matches the reference model; done spacing exactly WIDTH+2 cycles.
